// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy
// flags, and one-cycle overflow/underflow pulses for rejected requests.
module param_sync_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int PTR_W         = $clog2(DEPTH),
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_W:0]        count,
  output logic [PTR_W-1:0]      wr_ptr,
  output logic [PTR_W-1:0]      rd_ptr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_AFULL  = (PTR_W+1)'(AFULL_THRESH);
  localparam logic [PTR_W:0]   CNT_AEMPTY = (PTR_W+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_ok, pop_ok;

  // Flags come straight from the registered count, so they only move at the edge.
  assign full         = (count_q == CNT_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AFULL);
  assign almost_empty = (count_q <= CNT_AEMPTY);

  // A pop frees a slot in the same cycle, so a full FIFO still takes push+pop.
  assign pop_ok  = pop  & ~empty & ~clear;
  assign push_ok = push & ~clear & (~full | pop_ok);

  // NOTE: every always_comb output gets its default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      overflow_d  = push & ~push_ok;
      underflow_d = pop  & ~pop_ok;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; stale words are never visible
  // because occupancy and pointers are reset, and this keeps the array mappable to RAM.
  always_ff @(posedge aclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (clear)       rdata_d = '0;
        else if (pop_ok) rdata_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) rdata_q <= '0;
        else         rdata_q <= rdata_d;
      end

      assign data_out = rdata_q;
    end else begin : g_fwft_read
      // Head entry is shown directly; a full push+pop reads the old head before the write lands.
      assign data_out = empty ? '0 : mem_q[rd_ptr_q];
    end
  endgenerate

  assign count     = count_q;
  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Runs a registered-read and a FWFT instance side by side on identical stimulus
// and checks both against a queue-based model every cycle, plus literal spot checks.
module tb_param_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int PW    = 4;

  logic          aclk    = 1'b0;
  logic          resetn  = 1'b0;
  logic          clear   = 1'b0;
  logic          push    = 1'b0;
  logic          pop     = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] d0_data_out, d1_data_out;
  logic          d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic          d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
  logic [PW:0]   d0_count, d1_count;
  logic [PW-1:0] d0_wp, d0_rp, d1_wp, d1_rp;

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .aclk(aclk), .resetn(resetn), .clear(clear), .push(push), .data_in(data_in),
    .pop(pop), .data_out(d0_data_out), .full(d0_full), .empty(d0_empty),
    .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
    .wr_ptr(d0_wp), .rd_ptr(d0_rp), .overflow(d0_ovf), .underflow(d0_unf)
  );

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .aclk(aclk), .resetn(resetn), .clear(clear), .push(push), .data_in(data_in),
    .pop(pop), .data_out(d1_data_out), .full(d1_full), .empty(d1_empty),
    .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
    .wr_ptr(d1_wp), .rd_ptr(d1_rp), .overflow(d1_ovf), .underflow(d1_unf)
  );

  always #5 aclk = ~aclk;

  // Reference model: a queue of stored words plus the few observable side registers.
  logic [DW-1:0] mq[$];
  int            m_wp   = 0;
  int            m_rp   = 0;
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf  = 0;
  bit            m_unf  = 0;

  int n_cmp  = 0;
  int n_err  = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wp = 0; m_rp = 0; m_dout = '0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_edge();
    bit pop_ok, push_ok;
    if (clear) begin
      model_reset();
    end else begin
      pop_ok  = pop && (mq.size() != 0);
      push_ok = push && (mq.size() != DEPTH || pop_ok);
      if (pop_ok) begin
        m_dout = mq.pop_front();
        m_rp   = (m_rp + 1) % DEPTH;
      end
      if (push_ok) begin
        mq.push_back(data_in);
        m_wp = (m_wp + 1) % DEPTH;
      end
      m_ovf = push && !push_ok;
      m_unf = pop && !pop_ok;
    end
  endtask

  task automatic cmp_dut(input string tag, input logic [DW-1:0] dout, input logic [PW:0] cnt,
                         input logic [PW-1:0] wp, input logic [PW-1:0] rp,
                         input logic f, input logic e, input logic af, input logic ae,
                         input logic ov, input logic un, input logic [DW-1:0] exp_dout);
    int sz;
    sz = mq.size();
    check({tag, "_count"}, DW'(cnt), DW'(sz));
    check({tag, "_wr_ptr"}, DW'(wp), DW'(m_wp));
    check({tag, "_rd_ptr"}, DW'(rp), DW'(m_rp));
    check({tag, "_full"}, DW'(f), DW'(sz == DEPTH));
    check({tag, "_empty"}, DW'(e), DW'(sz == 0));
    check({tag, "_almost_full"}, DW'(af), DW'(sz >= DEPTH - 2));
    check({tag, "_almost_empty"}, DW'(ae), DW'(sz <= 2));
    check({tag, "_overflow"}, DW'(ov), DW'(m_ovf));
    check({tag, "_underflow"}, DW'(un), DW'(m_unf));
    check({tag, "_data_out"}, dout, exp_dout);
  endtask

  initial begin
    forever begin
      @(negedge aclk);
      if (chk_en) begin
        cmp_dut("std", d0_data_out, d0_count, d0_wp, d0_rp, d0_full, d0_empty,
                d0_af, d0_ae, d0_ovf, d0_unf, m_dout);
        cmp_dut("fwft", d1_data_out, d1_count, d1_wp, d1_rp, d1_full, d1_empty,
                d1_af, d1_ae, d1_ovf, d1_unf, (mq.size() != 0) ? mq[0] : '0);
      end
    end
  end

  // Drive one cycle of inputs from a negedge, advance the model at the edge, return at next negedge.
  task automatic step(input bit ps, input logic [DW-1:0] d, input bit pp, input bit cl);
    push = ps; data_in = d; pop = pp; clear = cl;
    @(posedge aclk);
    model_edge();
    @(negedge aclk);
    push = 1'b0; pop = 1'b0; clear = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_std_count"}, DW'(d0_count), 0);
    check({tag, "_std_wr_ptr"}, DW'(d0_wp), 0);
    check({tag, "_std_rd_ptr"}, DW'(d0_rp), 0);
    check({tag, "_std_data_out"}, d0_data_out, 0);
    check({tag, "_std_empty"}, DW'(d0_empty), 1);
    check({tag, "_std_almost_empty"}, DW'(d0_ae), 1);
    check({tag, "_std_full"}, DW'(d0_full), 0);
    check({tag, "_std_almost_full"}, DW'(d0_af), 0);
    check({tag, "_std_overflow"}, DW'(d0_ovf), 0);
    check({tag, "_std_underflow"}, DW'(d0_unf), 0);
    check({tag, "_fwft_data_out"}, d1_data_out, 0);
    check({tag, "_fwft_count"}, DW'(d1_count), 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge aclk);
    chk_en = 1;
    @(negedge aclk);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Fill to full, watching almost_full turn on at 14, then one rejected push.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, DW'(32'h100 + i), 0, 0);
      if (i == 12) check("fill_af_at_13", DW'(d0_af), 0);
      if (i == 13) check("fill_af_at_14", DW'(d0_af), 1);
    end
    check("fill_full", DW'(d0_full), 1);
    check("fill_count", DW'(d0_count), 16);
    step(1, 32'h200, 0, 0);
    check("ovf_pulse", DW'(d0_ovf), 1);
    check("ovf_count_held", DW'(d0_count), 16);
    step(0, 0, 0, 0);
    check("ovf_one_cycle", DW'(d0_ovf), 0);

    // Drain with registered read, then one rejected pop.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0);
      check($sformatf("drain_data_%0d", i), d0_data_out, DW'(32'h100 + i));
    end
    check("drain_empty", DW'(d0_empty), 1);
    step(0, 0, 1, 0);
    check("unf_pulse", DW'(d0_unf), 1);
    step(0, 0, 0, 0);
    check("unf_one_cycle", DW'(d0_unf), 0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < DEPTH; i++) step(1, DW'(32'h100 + i), 0, 0);
    step(1, 32'hAAAA, 1, 0);
    check("fullpp_std_data", d0_data_out, 32'h100);
    check("fullpp_fwft_head", d1_data_out, 32'h101);
    check("fullpp_count", DW'(d0_count), 16);
    check("fullpp_no_ovf", DW'(d0_ovf), 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
    check("fullpp_last_read", d0_data_out, 32'hAAAA);

    // Pointer wrap with order preserved.
    step(0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, DW'(32'h300 + i), 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(1, DW'(32'h400 + i), 0, 0);
    check("wrap_wr_ptr", DW'(d0_wp), 8);
    check("wrap_rd_ptr", DW'(d0_rp), 12);
    check("wrap_count", DW'(d0_count), 12);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
    check("wrap_last_read", d0_data_out, 32'h40B);

    // FWFT shows a word pushed into an empty FIFO on the next cycle.
    check("fwft_empty_zero", d1_data_out, 0);
    step(1, 32'hDEAD, 0, 0);
    check("fwft_fallthrough", d1_data_out, 32'hDEAD);
    check("std_held", d0_data_out, 32'h40B);
    step(0, 0, 1, 0);

    // Randomized traffic with shifting push/pop bias to visit full and empty.
    for (int ph = 0; ph < 4; ph++) begin
      int push_pct;
      push_pct = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      for (int n = 0; n < 600; n++) begin
        step($urandom_range(0, 99) < push_pct, $urandom,
             $urandom_range(0, 99) < (100 - push_pct), $urandom_range(0, 99) == 0);
      end
    end

    // Clear beats push and pop.
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, DW'(32'h500 + i), 0, 0);
    step(0, 0, 1, 0);
    step(1, 32'h505, 0, 0);
    check("pre_clear_count", DW'(d0_count), 5);
    step(1, 32'hBEEF, 1, 1);
    check("clear_count", DW'(d0_count), 0);
    check("clear_empty", DW'(d0_empty), 1);
    check("clear_std_data", d0_data_out, 0);
    check("clear_fwft_data", d1_data_out, 0);
    check("clear_no_ovf", DW'(d0_ovf), 0);
    check("clear_no_unf", DW'(d0_unf), 0);

    // Asynchronous reset in the middle of a cycle, with words queued and a pop read out.
    for (int i = 0; i < 4; i++) step(1, DW'(32'h600 + i), 0, 0);
    step(0, 0, 1, 0);
    @(posedge aclk);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(negedge aclk);
    resetn = 1'b1;
    step(0, 0, 1, 0);
    check("post_rst_unf", DW'(d0_unf), 1);
    step(0, 0, 0, 0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
